// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//
// Round-robin arbiter and data mux for the Argon shared unit bus. Up to UNITS
// requesters each issue one-word transfers tagged with a destination unit ID.
// Requester index i carries unit ID i+1. Transfers are serialised onto one
// registered bus with a valid/ready handshake. A stall watchdog aborts a
// transfer whose destination never accepts it.
//
// Optional feature (compile-time macro): BUS_LOCK_EN
//   Defined   : a granted unit holding i_lock and i_req at completion keeps
//               priority for the next arbitration. Timeouts always rotate.
//   Undefined : i_lock is ignored; the port stays for interface stability.
//
// Ports
//   clk          in   rising-edge clock for all logic
//   rst          in   synchronous active-high reset
//   i_req        in   [UNITS]          per-unit transfer request
//   i_data       in   [UNITS*WORDSIZE] per-unit payload, unit i at i*WORDSIZE
//   i_dest       in   [UNITS*IDW]      per-unit destination ID, same packing
//   i_lock       in   [UNITS]          per-unit bus-hold request
//   o_grant      out  [UNITS]          one-hot owner of the current transfer
//   o_bus_valid  out                   bus word valid
//   o_bus_data   out  [WORDSIZE]       latched payload
//   o_bus_src    out  [IDW]            ID of the granted unit
//   o_bus_dest   out  [IDW]            latched destination ID
//   i_bus_ready  in                    destination accepts the word
//   o_timeout    out                   one-cycle pulse on an aborted transfer
// -----------------------------------------------------------------------------
module bus_arbiter #(
    parameter int WORDSIZE = 16,
    parameter int UNITS    = 5,
    parameter int IDW      = 4,
    parameter int TIMEOUT  = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [UNITS-1:0]          i_req,
    input  logic [UNITS*WORDSIZE-1:0] i_data,
    input  logic [UNITS*IDW-1:0]      i_dest,
    input  logic [UNITS-1:0]          i_lock,
    output logic [UNITS-1:0]          o_grant,
    output logic                      o_bus_valid,
    output logic [WORDSIZE-1:0]       o_bus_data,
    output logic [IDW-1:0]            o_bus_src,
    output logic [IDW-1:0]            o_bus_dest,
    input  logic                      i_bus_ready,
    output logic                      o_timeout
);

    localparam int PW = (UNITS > 1) ? $clog2(UNITS) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         ptr_q, ptr_d;
    logic [PW-1:0]         gidx_q, gidx_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [UNITS-1:0]      grant_q, grant_d;
    logic                  valid_q, valid_d;
    logic [WORDSIZE-1:0]   data_q, data_d;
    logic [IDW-1:0]        src_q, src_d;
    logic [IDW-1:0]        dest_q, dest_d;
    logic                  timeout_q, timeout_d;

    // Per-unit views of the packed payload and destination buses.
    logic [WORDSIZE-1:0]   data_arr [UNITS];
    logic [IDW-1:0]        dest_arr [UNITS];

    generate
        for (genvar gi = 0; gi < UNITS; gi++) begin : g_unpack
            assign data_arr[gi] = i_data[gi*WORDSIZE +: WORDSIZE];
            assign dest_arr[gi] = i_dest[gi*IDW +: IDW];
        end
    endgenerate

`ifndef BUS_LOCK_EN
    // Lock requests have no effect in this build.
    logic unused_lock;
    assign unused_lock = ^i_lock;
`endif

    // -------------------------------------------------------------------------
    // Round-robin pick: first requester at or above ptr, wrapping to 0.
    // Scanning the offsets from the far end down lets the nearest offset
    // overwrite the others, so no early exit is needed.
    // -------------------------------------------------------------------------
    logic          sel_found;
    logic [PW-1:0] sel_idx;

    always_comb begin : arb_select
        int t;
        t         = 0;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int k = UNITS - 1; k >= 0; k--) begin
            t = int'(ptr_q) + k;
            if (t >= UNITS) begin
                t = t - UNITS;
            end
            if (i_req[PW'(t)]) begin
                sel_found = 1'b1;
                sel_idx   = PW'(t);
            end
        end
    end

    // Pointer value after the current owner finishes: owner+1 mod UNITS.
    logic [PW-1:0] next_ptr;
    assign next_ptr = (gidx_q == PW'(UNITS - 1)) ? '0 : gidx_q + PW'(1);

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin : fsm_next
        state_d   = state_q;
        ptr_d     = ptr_q;
        gidx_d    = gidx_q;
        cnt_d     = cnt_q;
        grant_d   = grant_q;
        valid_d   = valid_q;
        data_d    = data_q;
        src_d     = src_q;
        dest_d    = dest_q;
        timeout_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    grant_d          = '0;
                    grant_d[sel_idx] = 1'b1;
                    valid_d          = 1'b1;
                    data_d           = data_arr[sel_idx];
                    dest_d           = dest_arr[sel_idx];
                    src_d            = IDW'(sel_idx) + IDW'(1);
                    gidx_d           = sel_idx;
                    cnt_d            = '0;
                    state_d          = BUSY;
                end
            end

            BUSY: begin
                // valid is always high in BUSY, so ready alone completes.
                // Ready wins over a watchdog expiry in the same cycle.
                if (i_bus_ready) begin
                    grant_d = '0;
                    valid_d = 1'b0;
                    ptr_d   = next_ptr;
`ifdef BUS_LOCK_EN
                    if (i_lock[gidx_q] && i_req[gidx_q]) begin
                        ptr_d = gidx_q;
                    end
`endif
                    state_d = IDLE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    // TIMEOUT-th valid cycle without ready: abort. The pulse
                    // lands on the cycle after, when valid has dropped.
                    grant_d   = '0;
                    valid_d   = 1'b0;
                    ptr_d     = next_ptr;
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            gidx_q    <= '0;
            cnt_q     <= '0;
            grant_q   <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            src_q     <= '0;
            dest_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gidx_q    <= gidx_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            src_q     <= src_d;
            dest_q    <= dest_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_grant     = grant_q;
    assign o_bus_valid = valid_q;
    assign o_bus_data  = data_q;
    assign o_bus_src   = src_q;
    assign o_bus_dest  = dest_q;
    assign o_timeout   = timeout_q;

endmodule
